// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: data-cache handshake, store lane formatting,
// load byte/half selection with sign/zero extension, and pipeline stall.
module mem_stage_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            M_mem_rd,
  input  logic            M_mem_wr,
  input  logic [2:0]      M_funct3,
  input  logic [XLEN-1:0] M_alu_out,
  input  logic [XLEN-1:0] M_rs2_data,
  output logic            waiting,
  output logic            mem_err,
  output logic [XLEN-1:0] ld_data,
  output logic            dc_req,
  output logic            dc_we,
  output logic [XLEN-1:0] dc_addr,
  output logic [XLEN-1:0] dc_wdata,
  output logic [3:0]      dc_wstrb,
  input  logic            dc_ready,
  input  logic [XLEN-1:0] dc_rdata
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic       is_load;
  logic       is_store;
  logic       f3_legal;
  logic       aligned;
  logic       acc_ok;
  logic       acc_err;

  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;

  logic [1:0]      lat_off;
  logic [2:0]      lat_f3;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  // Decode the MEM-stage instruction into a legal, aligned access or an error
  always_comb begin
    is_load  = M_mem_rd & ~M_mem_wr;
    is_store = M_mem_wr & ~M_mem_rd;

    f3_legal = 1'b0;
    if (is_load) begin
      case (M_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
        default:                        f3_legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (M_funct3)
        F3_B, F3_H, F3_W: f3_legal = 1'b1;
        default:          f3_legal = 1'b0;
      endcase
    end

    // Access size lives in funct3[1:0]; the unsigned bit does not affect alignment
    case (M_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~M_alu_out[0];
      2'b10:   aligned = (M_alu_out[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase

    acc_ok  = (is_load | is_store) & f3_legal & aligned;
    acc_err = (M_mem_rd & M_mem_wr) | ((is_load | is_store) & ~(f3_legal & aligned));
  end

  // Errors are only reported while idle; a faulting instruction never stalls
  assign mem_err = (state == IDLE) & acc_err;

  // Stall from the detect cycle through every cycle spent waiting on the cache
  assign waiting = ((state == IDLE) & acc_ok) | (state == BUSY);

  // Replicate store data onto all lanes and build the byte strobes
  always_comb begin
    st_wdata = '0;
    st_wstrb = 4'b0000;
    if (is_store) begin
      case (M_funct3[1:0])
        2'b00: begin
          st_wdata = {4{M_rs2_data[7:0]}};
          st_wstrb = 4'b0001 << M_alu_out[1:0];
        end
        2'b01: begin
          st_wdata = {2{M_rs2_data[15:0]}};
          st_wstrb = 4'b0011 << M_alu_out[1:0];
        end
        2'b10: begin
          st_wdata = M_rs2_data;
          st_wstrb = 4'b1111;
        end
        default: begin
          st_wdata = '0;
          st_wstrb = 4'b0000;
        end
      endcase
    end
  end

  // Select the addressed byte/half of the returned word and extend it
  always_comb begin
    case (lat_off)
      2'd0:    ld_byte = dc_rdata[7:0];
      2'd1:    ld_byte = dc_rdata[15:8];
      2'd2:    ld_byte = dc_rdata[23:16];
      default: ld_byte = dc_rdata[31:24];
    endcase

    ld_half = lat_off[1] ? dc_rdata[31:16] : dc_rdata[15:0];

    case (lat_f3)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_ext = {24'd0, ld_byte};
      F3_HU:   ld_ext = {16'd0, ld_half};
      default: ld_ext = dc_rdata;
    endcase
  end

  // Access sequencer: issue request, hold it until the cache completes, then release
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dc_req   <= 1'b0;
      dc_we    <= 1'b0;
      dc_addr  <= '0;
      dc_wdata <= '0;
      dc_wstrb <= 4'b0000;
      ld_data  <= '0;
      lat_off  <= 2'b00;
      lat_f3   <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (acc_ok) begin
            state    <= BUSY;
            dc_req   <= 1'b1;
            dc_we    <= is_store;
            dc_addr  <= {M_alu_out[XLEN-1:2], 2'b00};
            dc_wdata <= st_wdata;
            dc_wstrb <= st_wstrb;
            lat_off  <= M_alu_out[1:0];
            lat_f3   <= M_funct3;
          end
        end
        BUSY: begin
          if (dc_ready) begin
            state  <= DONE;
            dc_req <= 1'b0;
            if (!dc_we) begin
              ld_data <= ld_ext;
            end
          end
        end
        // M_* still shows the finished instruction here, so never restart from DONE
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
